// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, constants and sigma helpers for the SHA-256 message schedule
package sha256_pkg;

  localparam int ROUNDS = 64;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - schedule word stream from the scheduler to the round engine
// wt_par exists only when SHA256_SCHED_PARITY_EN is defined.
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic       wt_valid;
  logic       wt_ready;
  word_t      wt;
  logic [5:0] round;
`ifdef SHA256_SCHED_PARITY_EN
  logic       wt_par;
`endif

`ifdef SHA256_SCHED_PARITY_EN
  modport master (output wt_valid, output wt, output round, output wt_par, input wt_ready);
  modport slave  (input wt_valid, input wt, input round, input wt_par, output wt_ready);
`else
  modport master (output wt_valid, output wt, output round, input wt_ready);
  modport slave  (input wt_valid, input wt, input round, output wt_ready);
`endif

endinterface

// File: rtl/sha256_small_sigma.sv
// rtl/sha256_small_sigma.sv - combinational next-word adder: W_{t+16} from the sliding window
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t next_w
);

  assign next_w = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - captures a 16-word block and streams the 64 schedule words
// Optional parity output on the stream is enabled by SHA256_SCHED_PARITY_EN.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  word_t                        w_in [16],
  sha256_msg_schedule_if.master        wt_if,
  output logic                         done
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  sched_state_e state, state_nx;
  word_t        win [16];
  logic [5:0]   round_q;
  word_t        next_w;
  logic         hs;
  logic         capture;
  logic         shift;
  logic         clr_round;

  sha256_small_sigma u_sigma (
    .w0    (win[0]),
    .w1    (win[1]),
    .w9    (win[9]),
    .w14   (win[14]),
    .next_w(next_w)
  );

  assign hs = (state == RUN) && wt_if.wt_ready;

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    shift     = 1'b0;
    clr_round = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          capture  = 1'b1;
        end
      end
      RUN: begin
        // Dropping start wins over a same-cycle handshake: the word is discarded.
        if (!start) begin
          state_nx  = IDLE;
          clr_round = 1'b1;
        end else if (hs) begin
          shift = 1'b1;
          if (round_q == LAST_ROUND) state_nx = DONE;
        end
      end
      DONE: begin
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      round_q <= '0;
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        round_q <= '0;
        for (int k = 0; k < 16; k++) win[k] <= w_in[k];
      end else if (shift) begin
        // Round saturates at the last index so DONE still reports 63.
        if (round_q != LAST_ROUND) round_q <= round_q + 6'd1;
        for (int k = 0; k < 15; k++) win[k] <= win[k+1];
        win[15] <= next_w;
      end else if (clr_round) begin
        round_q <= '0;
      end
    end
  end

`ifdef SHA256_SCHED_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (capture) begin
      par_q <= ^w_in[0];
    end else if (shift) begin
      par_q <= ^win[1];
    end
  end

  assign wt_if.wt_par = par_q;
`endif

  assign wt_if.wt_valid = (state == RUN);
  assign wt_if.wt       = win[0];
  assign wt_if.round    = round_q;
  assign done           = (state == DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - randomized self-checking bench against a full-array schedule model
module tb_sha256_msg_schedule;
  import sha256_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  start;
  word_t w_in [16];
  logic  done;

  word_t blk   [16];
  word_t exp_w [64];
  word_t got   [64];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc;

  sha256_msg_schedule_if sif ();

  sha256_msg_schedule dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .w_in (w_in),
    .wt_if(sif),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook recurrence over the whole array, W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int k = 0; k < 16; k++) blk[k] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_zero();
    for (int k = 0; k < 16; k++) blk[k] = '0;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 16; k++) blk[k] = $urandom;
  endtask

  task automatic begin_block();
    @(negedge clk);
    build_model();
    for (int k = 0; k < 16; k++) w_in[k] = blk[k];
    start = 1'b1;
  endtask

  task automatic end_block();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("done_clear", {31'b0, done}, 32'd0);
  endtask

  task automatic stream(input int pct, input int stall_at, input int stall_len,
                        input int stop_at, input bit scribble, output int cycles);
    int idx = 0;
    int stalled = 0;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (cycles > 3000) begin
        check("timeout_idx", idx, 64);
        return;
      end
      if (idx == stop_at) return;
      if (idx == 64) begin
        check("done_set", {31'b0, done}, 32'd1);
        check("valid_after", {31'b0, sif.wt_valid}, 32'd0);
        return;
      end
      check("valid", {31'b0, sif.wt_valid}, 32'd1);
      check($sformatf("wt[%0d]", idx), sif.wt, exp_w[idx]);
      check("round", {26'b0, sif.round}, idx);
      check("done_low", {31'b0, done}, 32'd0);
`ifdef SHA256_SCHED_PARITY_EN
      check("wt_par", {31'b0, sif.wt_par}, {31'b0, ^exp_w[idx]});
`endif
      got[idx] = sif.wt;
      if (idx == stall_at && stalled < stall_len) begin
        sif.wt_ready = 1'b0;
        stalled++;
      end else begin
        sif.wt_ready = ($urandom_range(0, 99) < pct);
      end
      if (sif.wt_ready) idx++;
      if (scribble) w_in[$urandom_range(0, 15)] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    sif.wt_ready = 1'b0;
    for (int k = 0; k < 16; k++) w_in[k] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, sif.wt_valid}, 32'd0);
    check("rst_wt", sif.wt, 32'd0);
    check("rst_round", {26'b0, sif.round}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b1;

    // "abc" block at full rate, then hold done with start high
    set_abc();
    begin_block();
    stream(100, -1, 0, 99, 1'b0, cyc);
    check("abc_cycles", cyc, 65);
    check("abc_w0", got[0], 32'h61626380);
    check("abc_w15", got[15], 32'h00000018);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);
    repeat (10) begin
      @(negedge clk);
      check("hold_done", {31'b0, done}, 32'd1);
      check("hold_valid", {31'b0, sif.wt_valid}, 32'd0);
      check("hold_round", {26'b0, sif.round}, 32'd63);
    end
    end_block();

    // all-zero block
    set_zero();
    begin_block();
    stream(100, -1, 0, 99, 1'b0, cyc);
    check("zero_cycles", cyc, 65);
    end_block();

    // stall at round 16 for five cycles
    set_abc();
    begin_block();
    stream(100, 16, 5, 99, 1'b0, cyc);
    check("stall_cycles", cyc, 70);
    check("stall_w17", got[17], 32'h000F0000);
    end_block();

    // abort at round 20 with an in-flight handshake, then zero block
    set_abc();
    begin_block();
    stream(100, -1, 0, 20, 1'b0, cyc);
    start = 1'b0;
    sif.wt_ready = 1'b1;
    @(negedge clk);
    check("abort_valid", {31'b0, sif.wt_valid}, 32'd0);
    check("abort_round", {26'b0, sif.round}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_done", {31'b0, done}, 32'd0);
    end
    set_zero();
    begin_block();
    stream(100, -1, 0, 99, 1'b0, cyc);
    end_block();

    // reset at round 30 with start held high, then recapture
    set_rand();
    begin_block();
    stream(100, -1, 0, 30, 1'b0, cyc);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", {31'b0, sif.wt_valid}, 32'd0);
    check("mrst_round", {26'b0, sif.round}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_wt", sif.wt, 32'd0);
    rst = 1'b1;
    stream(100, -1, 0, 99, 1'b0, cyc);
    end_block();

    // random blocks, random back-pressure, w_in disturbed after capture
    repeat (4) begin
      set_rand();
      begin_block();
      stream(60, -1, 0, 99, 1'b1, cyc);
      end_block();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
